thread_regfile: RTL and testbench

- Per-thread register file that sits directly upstream of the ALU in each compute thread lane.
- Supplies the rs/rt operands that the ALU consumes during EXECUTE.
- Writes back the ALU result, the LSU load data or a decoded immediate during UPDATE.
- Holds 13 general-purpose 8-bit registers plus 3 read-only identity registers (block id, block dim, thread id).

---
 rtl/thread_regfile_pkg.sv | 33 +++
 rtl/thread_regfile.sv | 101 ++++++++++
 tb/tb_thread_regfile.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/thread_regfile_pkg.sv
// Purpose: shared encodings for the per-thread register file (core FSM states, write-source select, register map).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package thread_regfile_pkg;

    // Core FSM state as broadcast to every lane.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_t;

    // Write-back source select.
    typedef enum logic [1:0] {
        MUX_ALU  = 2'b00,
        MUX_LSU  = 2'b01,
        MUX_IMM  = 2'b10,
        MUX_RSVD = 2'b11
    } reg_mux_t;

    // Register map: R0..R12 general purpose, R13..R15 read-only identity.
    localparam int          NUM_GP_REGS   = 13;
    localparam int          NUM_REGS      = 16;
    localparam logic [3:0]  REG_BLOCK_ID  = 4'd13;
    localparam logic [3:0]  REG_BLOCK_DIM = 4'd14;
    localparam logic [3:0]  REG_THREAD_ID = 4'd15;

endpackage

// File: rtl/thread_regfile.sv
// Purpose: per-thread register file feeding rs/rt to the ALU/LSU and taking ALU/LSU/immediate write-back.
// Latency: operands registered on the REQUEST edge, valid the cycle after; writes land on the UPDATE edge.
// Backpressure: none; enable low freezes all state and outputs.
//
// Ports: clock, reset (async active-low), enable, block_id, core_state,
//        decoded_{rd,rs,rt}_address, decoded_reg_write_enable, decoded_reg_input_mux,
//        decoded_immediate, alu_out, lsu_out -> rs, rt.
// Build option: REGFILE_ZERO_REG_EN makes R0 read as zero and ignore writes.
module thread_regfile
    import thread_regfile_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    logic [DATA_BITS-1:0] gp_regs [NUM_GP_REGS];
    logic [DATA_BITS-1:0] block_id_q;
    logic [DATA_BITS-1:0] reg_view [NUM_REGS];
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_src_ok;
    logic                 wr_en;
    core_state_t          state;

    assign state = core_state_t'(core_state);

    // Architectural view of all 16 registers. Block dim and thread id are
    // elaboration-time constants, so they need no storage.
    always_comb begin
        for (int i = 0; i < NUM_GP_REGS; i++) begin
            reg_view[i] = gp_regs[i];
        end
        reg_view[REG_BLOCK_ID]  = block_id_q;
        reg_view[REG_BLOCK_DIM] = DATA_BITS'(THREADS_PER_BLOCK);
        reg_view[REG_THREAD_ID] = DATA_BITS'(THREAD_ID);
`ifdef REGFILE_ZERO_REG_EN
        reg_view[0] = '0;
`endif
    end

    // Write-back source select; the reserved code suppresses the write.
    always_comb begin
        wr_data   = alu_out;
        wr_src_ok = 1'b1;
        case (reg_mux_t'(decoded_reg_input_mux))
            MUX_ALU:  wr_data = alu_out;
            MUX_LSU:  wr_data = lsu_out;
            MUX_IMM:  wr_data = decoded_immediate;
            default:  wr_src_ok = 1'b0;
        endcase
    end

    // Identity registers (and R0 when hard-wired) silently drop writes.
    always_comb begin
        wr_en = (state == ST_UPDATE) && decoded_reg_write_enable && wr_src_ok
                && (decoded_rd_address < REG_BLOCK_ID);
`ifdef REGFILE_ZERO_REG_EN
        if (decoded_rd_address == 4'd0) begin
            wr_en = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GP_REGS; i++) begin
                gp_regs[i] <= '0;
            end
            block_id_q <= '0;
            rs         <= '0;
            rt         <= '0;
        end else if (enable) begin
            block_id_q <= block_id;
            // Reads and writes live in disjoint core states, so no bypass is needed.
            if (state == ST_REQUEST) begin
                rs <= reg_view[decoded_rs_address];
                rt <= reg_view[decoded_rt_address];
            end
            if (wr_en) begin
                gp_regs[decoded_rd_address] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_thread_regfile.sv
module tb_thread_regfile;
    import thread_regfile_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif
    localparam int TPB = 4;
    localparam int TID = 2;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] rd_a, rs_a, rt_a;
    logic       we;
    logic [1:0] mux;
    logic [7:0] imm, alu_out, lsu_out;
    logic [7:0] rs, rt;

    int total = 0;
    int bad   = 0;

    thread_regfile #(.THREADS_PER_BLOCK(TPB), .THREAD_ID(TID), .DATA_BITS(8)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .enable                   (enable),
        .block_id                 (block_id),
        .core_state               (core_state),
        .decoded_rd_address       (rd_a),
        .decoded_rs_address       (rs_a),
        .decoded_rt_address       (rt_a),
        .decoded_reg_write_enable (we),
        .decoded_reg_input_mux    (mux),
        .decoded_immediate        (imm),
        .alu_out                  (alu_out),
        .lsu_out                  (lsu_out),
        .rs                       (rs),
        .rt                       (rt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model: register array + operand latches ----------------
    int         mreg [16];
    logic [7:0] m_rs, m_rt;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 0;
        mreg[14] = TPB;
        mreg[15] = TID;
        m_rs = 8'h00;
        m_rt = 8'h00;
    endtask

    function automatic logic [7:0] mread(input int a);
        if (ZERO_R0 && a == 0) return 8'h00;
        return 8'(mreg[a]);
    endfunction

    // One enabled clock as the architecture describes it: read old values, then write.
    task automatic model_clk();
        int r;
        if (!enable) return;
        if (core_state == 3'b011) begin
            m_rs = mread(int'(rs_a));
            m_rt = mread(int'(rt_a));
        end
        r = int'(rd_a);
        if (core_state == 3'b110 && we && r <= 12 && !(ZERO_R0 && r == 0)) begin
            if (mux == 2'd0) mreg[r] = int'(alu_out);
            else if (mux == 2'd1) mreg[r] = int'(lsu_out);
            else if (mux == 2'd2) mreg[r] = int'(imm);
        end
        mreg[13] = int'(block_id);
    endtask

    task automatic step();
        model_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] blk, input logic [2:0] st,
                         input logic [3:0] ra, input logic [3:0] ta, input logic [3:0] da,
                         input logic w, input logic [1:0] m, input logic [7:0] im,
                         input logic [7:0] al, input logic [7:0] ls);
        enable = en; block_id = blk; core_state = st;
        rs_a = ra; rt_a = ta; rd_a = da; we = w; mux = m;
        imm = im; alu_out = al; lsu_out = ls;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       en;
        logic [7:0] blk;
        logic [2:0] st;
        logic [3:0] ra, ta, da;
        logic       w;
        logic [1:0] m;
        logic [7:0] im, al, ls;
        logic [7:0] exp_rs, exp_rt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [7:0] blk, input logic [2:0] st,
                                input logic [3:0] ra, input logic [3:0] ta, input logic [3:0] da,
                                input logic w, input logic [1:0] m, input logic [7:0] im,
                                input logic [7:0] al, input logic [7:0] ls,
                                input logic [7:0] ers, input logic [7:0] ert);
        vec_t v;
        v.en = en; v.blk = blk; v.st = st; v.ra = ra; v.ta = ta; v.da = da;
        v.w = w; v.m = m; v.im = im; v.al = al; v.ls = ls;
        v.exp_rs = ers; v.exp_rt = ert;
        return v;
    endfunction

    initial begin
        logic [7:0] r0_exp;
        r0_exp = ZERO_R0 ? 8'h00 : 8'h08;

        //                en blk    state       rs  rt  rd  we mux imm    alu    lsu     rs     rt
        vecs.push_back(mk(1, 8'd0, ST_REQUEST, 14, 15,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h02));
        vecs.push_back(mk(1, 8'd7, ST_IDLE,     0,  0,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h02));
        vecs.push_back(mk(1, 8'd7, ST_REQUEST, 13, 14,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h07, 8'h04));
        vecs.push_back(mk(0, 8'd9, ST_REQUEST, 13, 13,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h07, 8'h04));
        vecs.push_back(mk(0, 8'd9, ST_UPDATE,  13, 13,  1, 1, 2, 8'h5A, 8'h00, 8'h00, 8'h07, 8'h04));
        vecs.push_back(mk(0, 8'd9, ST_REQUEST, 13, 13,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h07, 8'h04));
        vecs.push_back(mk(1, 8'd9, ST_FETCH,    0,  0,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h07, 8'h04));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST, 13, 13,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0,  1, 1, 2, 8'h19, 8'hE1, 8'hD2, 8'h09, 8'h09));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0,  2, 1, 0, 8'h99, 8'h24, 8'hD2, 8'h09, 8'h09));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST,  1,  2,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h19, 8'h24));
        vecs.push_back(mk(1, 8'd9, ST_WAIT,     3,  3,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h19, 8'h24));
        vecs.push_back(mk(1, 8'd9, ST_EXECUTE,  3,  3,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h19, 8'h24));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0,  3, 1, 1, 8'h99, 8'hE1, 8'hA5, 8'h19, 8'h24));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0, 15, 1, 2, 8'hFF, 8'hE1, 8'hD2, 8'h19, 8'h24));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0,  4, 1, 3, 8'h33, 8'h11, 8'h22, 8'h19, 8'h24));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST,  3, 15,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h02));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST,  4,  4,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0,  5, 0, 2, 8'h77, 8'h77, 8'h77, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST,  5,  3,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0, 13, 1, 2, 8'h44, 8'h44, 8'h44, 8'h00, 8'hA5));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0, 14, 1, 0, 8'h45, 8'h45, 8'h45, 8'h00, 8'hA5));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST, 13, 14,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h09, 8'h04));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0,  0, 1, 2, 8'h08, 8'hE1, 8'hD2, 8'h09, 8'h04));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST,  0,  1,  0, 0, 0, 8'h00, 8'h00, 8'h00, r0_exp, 8'h19));
        vecs.push_back(mk(1, 8'd9, ST_DONE,     2,  2,  0, 0, 0, 8'h00, 8'h00, 8'h00, r0_exp, 8'h19));
        vecs.push_back(mk(1, 8'd9, ST_DECODE,   2,  2,  0, 0, 0, 8'h00, 8'h00, 8'h00, r0_exp, 8'h19));
        vecs.push_back(mk(1, 8'd9, ST_UPDATE,   0,  0, 12, 1, 2, 8'h5C, 8'hE1, 8'hD2, r0_exp, 8'h19));
        vecs.push_back(mk(1, 8'd9, ST_REQUEST, 12,  2,  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h5C, 8'h24));

        // ---------------- reset state ----------------
        model_reset();
        drive(1, 8'd0, ST_IDLE, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_rs", rs, 8'h00);
        chk("reset_rt", rt, 8'h00);
        // Request during reset must not load anything.
        drive(1, 8'd3, ST_REQUEST, 14, 15, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        @(posedge clock);
        #1;
        chk("reset_hold_rs", rs, 8'h00);
        chk("reset_hold_rt", rt, 8'h00);
        drive(1, 8'd0, ST_IDLE, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].blk, vecs[i].st, vecs[i].ra, vecs[i].ta, vecs[i].da,
                  vecs[i].w, vecs[i].m, vecs[i].im, vecs[i].al, vecs[i].ls);
            step();
            chk($sformatf("vec%0d_rs", i), rs, vecs[i].exp_rs);
            chk($sformatf("vec%0d_rt", i), rt, vecs[i].exp_rt);
        end

        // ---------------- reset mid-instruction ----------------
        drive(1, 8'd9, ST_UPDATE, 0, 0, 5, 1, 2, 8'h37, 8'hE1, 8'hD2);
        step();
        drive(1, 8'd9, ST_REQUEST, 5, 5, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step();
        chk("r5_written_rs", rs, 8'h37);
        chk("r5_written_rt", rt, 8'h37);
        drive(1, 8'd9, ST_WAIT, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_rs", rs, 8'h00);
        chk("async_reset_rt", rt, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        // R13 was cleared by reset; the REQUEST edge sees the old (zero) value.
        drive(1, 8'd9, ST_REQUEST, 5, 13, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step();
        chk("post_reset_r5", rs, 8'h00);
        chk("post_reset_r13", rt, 8'h00);
        drive(1, 8'd9, ST_REQUEST, 13, 14, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step();
        chk("post_reset_r13_track", rs, 8'h09);
        chk("post_reset_r14", rt, 8'h04);

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) != 0,
                  ($urandom_range(0, 7) == 0) ? 8'($urandom) : block_id,
                  3'($urandom_range(0, 7)),
                  4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
            step();
            chk($sformatf("rand%0d_rs", n), rs, m_rs);
            chk($sformatf("rand%0d_rt", n), rt, m_rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
